// File: rtl/cdsched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdsched_pkg
// Purpose  : Shared constants, state encoding and helpers for the
//            command/data routine round-robin scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package cdsched_pkg;

  localparam int NUM_REQ      = 4;
  localparam int VALUE_W      = 16;
  localparam int BUSY_TIMEOUT = 16;
  localparam int IDX_W        = 2;
  localparam int CNT_W        = $clog2(BUSY_TIMEOUT);

  // Requester slots
  localparam logic [IDX_W-1:0] REQ_MOVETOPOINT  = 2'd0;
  localparam logic [IDX_W-1:0] REQ_SETBACKLIGHT = 2'd1;
  localparam logic [IDX_W-1:0] REQ_FILLCOLOR    = 2'd2;
  localparam logic [IDX_W-1:0] REQ_PASSTHROUGH  = 2'd3;

  // Reset grant points at the last slot so the first search starts at slot 0.
  localparam logic [IDX_W-1:0] RESET_GRANT = REQ_PASSTHROUGH;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RELEASE   = 3'd4
  } sched_state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    idx_to_onehot      = '0;
    idx_to_onehot[idx] = 1'b1;
  endfunction

endpackage : cdsched_pkg
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Purpose  : Combinational 4-way round-robin picker. Searches the unmasked
//            requests starting one slot above 'last', wrapping upward.
// Ports    : req   [3:0] in  - request levels
//            mask  [3:0] in  - requests to ignore this cycle
//            last  [1:0] in  - most recently granted slot
//            valid       out - at least one unmasked request present
//            idx   [1:0] out - chosen slot (holds 'last' when !valid)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick4
  import cdsched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] eff_req;
  logic [IDX_W-1:0]   cand;

  assign eff_req = req & ~mask;

  always_comb begin
    valid = 1'b0;
    idx   = last;
    cand  = '0;
    // Offsets 1..NUM_REQ; the 2-bit add wraps naturally, and offset
    // NUM_REQ lands back on 'last' so a lone repeat request still wins.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + IDX_W'(k);
      if (!valid && eff_req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/cdroutine_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cdroutine_rr_scheduler
// Purpose  : Arbitrates four requesters onto one command/data routine.
//            Grants round-robin, issues a one-cycle go pulse, waits for the
//            routine's busy/idle handshake (with a timeout on busy rising),
//            then returns a one-cycle done pulse to the granted requester.
// Ports    : clk, rst                   - clock, sync active-high reset
//            go_req[3:0]                - request levels
//            commanddata_req[3:0]       - per-requester command/data flag
//            value_req[63:0]            - per-requester payload, 16b each
//            done_req[3:0]              - completion pulse (one-hot or 0)
//            go_cd, commanddata_cd,
//            value_cd[15:0]             - routine start pulse and operands
//            status_cd                  - routine busy
//            busy_sched                 - scheduler not idle
//            grant_idx[1:0]             - current / last granted slot
//            timeout_err                - sticky: routine never went busy
// Revision : 1.0 - initial release
// ============================================================================
module cdroutine_rr_scheduler
  import cdsched_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         go_req,
  input  logic [NUM_REQ-1:0]         commanddata_req,
  input  logic [NUM_REQ*VALUE_W-1:0] value_req,
  output logic [NUM_REQ-1:0]         done_req,
  output logic                       go_cd,
  output logic                       commanddata_cd,
  output logic [VALUE_W-1:0]         value_cd,
  input  logic                       status_cd,
  output logic                       busy_sched,
  output logic [IDX_W-1:0]           grant_idx,
  output logic                       timeout_err
);

  sched_state_t        state_q;
  logic [IDX_W-1:0]    grant_q;     // doubles as last_grant once released
  logic                cd_q;
  logic [VALUE_W-1:0]  value_q;
  logic                go_q;
  logic [NUM_REQ-1:0]  done_q;
  logic                busy_q;
  logic                tmo_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_REQ-1:0]  mask_q;      // suppresses the just-released slot

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;

  rr_pick4 u_pick (
    .req   (go_req),
    .mask  (mask_q),
    .last  (grant_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= RESET_GRANT;
      cd_q    <= 1'b0;
      value_q <= '0;
      go_q    <= 1'b0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      // Pulses default low; only the owning state raises them.
      go_q   <= 1'b0;
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          // The release mask lives for exactly one IDLE cycle.
          mask_q <= '0;
          if (pick_valid) begin
            grant_q <= pick_idx;
            cd_q    <= commanddata_req[pick_idx];
            value_q <= value_req[int'(pick_idx)*VALUE_W +: VALUE_W];
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // go_cd becomes visible one edge after arbitration.
          go_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (status_cd) begin
            state_q <= ST_WAIT_DONE;
          end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
            tmo_q   <= 1'b1;
            done_q  <= idx_to_onehot(grant_q);
            state_q <= ST_RELEASE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!status_cd) begin
            done_q  <= idx_to_onehot(grant_q);
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          mask_q  <= idx_to_onehot(grant_q);
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign done_req       = done_q;
  assign go_cd          = go_q;
  assign commanddata_cd = cd_q;
  assign value_cd       = value_q;
  assign busy_sched     = busy_q;
  assign grant_idx      = grant_q;
  assign timeout_err    = tmo_q;

endmodule : cdroutine_rr_scheduler
`default_nettype wire

// File: tb/tb_cdroutine_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdroutine_rr_scheduler
// Purpose  : Self-checking bench for cdroutine_rr_scheduler: table-driven
//            single transactions, randomized transactions against a
//            transaction-level reference, and hand sequences for rotation
//            and mid-transaction reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdroutine_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  go_req;
  logic [3:0]  commanddata_req;
  logic [63:0] value_req;
  logic [3:0]  done_req;
  logic        go_cd;
  logic        commanddata_cd;
  logic [15:0] value_cd;
  logic        status_cd;
  logic        busy_sched;
  logic [1:0]  grant_idx;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: last granted slot and sticky timeout expectation.
  logic [1:0] m_last;
  logic       m_tmo;

  always #5 clk = ~clk;

  cdroutine_rr_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .go_req         (go_req),
    .commanddata_req(commanddata_req),
    .value_req      (value_req),
    .done_req       (done_req),
    .go_cd          (go_cd),
    .commanddata_cd (commanddata_cd),
    .value_cd       (value_cd),
    .status_cd      (status_cd),
    .busy_sched     (busy_sched),
    .grant_idx      (grant_idx),
    .timeout_err    (timeout_err)
  );

  typedef struct {
    string      name;
    logic [3:0] req;
    logic [3:0] cd;
    logic [63:0] val;
    int         k;       // busy starts k cycles after go_cd; -1 = never
    int         blen;    // busy length in cycles
    bit         hold;    // requester keeps go one extra cycle after done
    logic [1:0] exp_g;
    logic       exp_tmo;
  } vec_t;

  vec_t tbl[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Round-robin rule: first requesting slot at (last+1), (last+2), ... mod 4.
  function automatic logic [1:0] model_pick(input logic [3:0] req, input logic [1:0] last);
    for (int s = 1; s <= 4; s++) begin
      int i;
      i = (int'(last) + s) % 4;
      if (req[i]) return 2'(i);
    end
    return last;
  endfunction

  task automatic do_reset(input bit with_checks);
    rst = 1'b1;
    go_req = '0; commanddata_req = '0; value_req = '0; status_cd = 1'b0;
    step();
    step();
    if (with_checks) begin
      check("reset go_cd",          go_cd,          0);
      check("reset done_req",       done_req,       0);
      check("reset busy_sched",     busy_sched,     0);
      check("reset commanddata_cd", commanddata_cd, 0);
      check("reset value_cd",       value_cd,       0);
      check("reset grant_idx",      grant_idx,      3);
      check("reset timeout_err",    timeout_err,    0);
    end
    rst = 1'b0;
    m_last = 2'd3;
    m_tmo  = 1'b0;
  endtask

  // One complete transaction from IDLE, with the routine modelled inline.
  task automatic run_txn(input string name, input logic [3:0] req, input logic [3:0] cd,
                         input logic [63:0] val, input int k, input int blen, input bit hold,
                         input logic [1:0] exp_g, input logic exp_tmo);
    int lat, done_c, ndone, ngo, exp_done;
    bit busy_after;
    logic [3:0]  done_v;
    logic [15:0] exp_val;
    exp_val  = val[16*exp_g +: 16];
    exp_done = (k < 0) ? 16 : k + blen + 1;
    done_c = -1; ndone = 0; ngo = 0; busy_after = 1'b0; done_v = '0;

    go_req = req; commanddata_req = cd; value_req = val;
    step();
    check({name, " grant"},          grant_idx,      exp_g);
    check({name, " value latched"},  value_cd,       exp_val);
    check({name, " cd latched"},     commanddata_cd, cd[exp_g]);
    check({name, " busy in issue"},  busy_sched,     1);
    check({name, " go not early"},   go_cd,          0);

    lat = 1;
    do begin
      step();
      lat++;
    end while (!go_cd && lat < 8);
    check({name, " go latency"}, lat, 2);
    if (go_cd) ngo = 1;

    status_cd = (k == 0);
    for (int c = 1; c <= exp_done + 5; c++) begin
      step();
      if (go_cd) ngo++;
      if (done_req != 0) begin
        ndone++;
        if (done_c < 0) begin
          done_c = c;
          done_v = done_req;
        end
      end
      if (c > exp_done && busy_sched) busy_after = 1'b1;
      status_cd = (k >= 0 && c >= k && c < k + blen);
      if (done_c >= 0 && c == done_c + (hold ? 2 : 1)) go_req = '0;
    end
    go_req = '0;
    status_cd = 1'b0;

    check({name, " done cycle"},    done_c,         exp_done);
    check({name, " done value"},    done_v,         4'b0001 << exp_g);
    check({name, " done once"},     ndone,          1);
    check({name, " go once"},       ngo,            1);
    check({name, " idle after"},    busy_after,     0);
    check({name, " timeout_err"},   timeout_err,    exp_tmo);
    check({name, " value held"},    value_cd,       exp_val);
    check({name, " cd held"},       commanddata_cd, cd[exp_g]);
    m_last = exp_g;
    m_tmo  = exp_tmo;
  endtask

  // All four held; each drops the cycle after its done. Expect 0,1,2,3.
  task automatic rr_sequence();
    int order[$];
    int busy_start, dbl, bad_oh;
    bit outstanding;
    logic [3:0] drop;
    busy_start = -100; dbl = 0; bad_oh = 0; outstanding = 1'b0; drop = '0;
    do_reset(0);
    go_req = 4'hF; commanddata_req = 4'b1010; value_req = 64'h4444_3333_2222_1111;
    for (int c = 0; c < 200; c++) begin
      step();
      go_req = go_req & ~drop;
      drop = '0;
      if (go_cd) begin
        if (outstanding) dbl++;
        outstanding = 1'b1;
        busy_start = c + 2;
      end
      if (done_req != 0) begin
        if ($countones(done_req) != 1) bad_oh++;
        for (int i = 0; i < 4; i++) if (done_req[i]) order.push_back(i);
        outstanding = 1'b0;
        drop = done_req;
      end
      status_cd = (c >= busy_start && c < busy_start + 2);
      if (order.size() >= 4 && go_req == 0 && !busy_sched) break;
    end
    status_cd = 1'b0;
    go_req = '0;
    check("rr count", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++)
      check($sformatf("rr order[%0d]", i), order[i], i);
    check("rr double go", dbl, 0);
    check("rr done onehot", bad_oh, 0);
  endtask

  // Reset while the routine is busy: abort without done, then recover.
  task automatic reset_mid();
    int bad;
    do_reset(0);
    go_req = 4'b0100; commanddata_req = 4'b0100; value_req = 64'h0000_5A5A_0000_0000;
    step();
    step();
    check("midrst go_cd", go_cd, 1);
    status_cd = 1'b1;
    repeat (4) step();
    check("midrst busy before", busy_sched, 1);
    rst = 1'b1;
    go_req = '0;
    step();
    rst = 1'b0;
    check("midrst go_cd",          go_cd,          0);
    check("midrst done_req",       done_req,       0);
    check("midrst busy_sched",     busy_sched,     0);
    check("midrst commanddata_cd", commanddata_cd, 0);
    check("midrst value_cd",       value_cd,       0);
    check("midrst grant_idx",      grant_idx,      3);
    check("midrst timeout_err",    timeout_err,    0);
    bad = 0;
    status_cd = 1'b0;
    repeat (6) begin
      step();
      if (done_req != 0 || busy_sched || go_cd) bad++;
    end
    check("midrst quiet", bad, 0);
    m_last = 2'd3;
    m_tmo  = 1'b0;
    run_txn("post-rst", 4'b0011, 4'b0001, 64'h0000_0000_BEEF_CAFE, 2, 2, 0, 2'd0, 1'b0);
  endtask

  initial begin
    tbl[0] = '{"single",   4'b0100, 4'b0100, 64'h1111_ABCD_2222_3333,  2, 5, 0, 2'd2, 1'b0};
    tbl[1] = '{"busy-now", 4'b1111, 4'b1000, 64'h7777_6666_5555_4444,  0, 1, 0, 2'd3, 1'b0};
    tbl[2] = '{"late15",   4'b0011, 4'b0001, 64'h0A0A_0B0B_0C0C_0D0D, 15, 3, 0, 2'd0, 1'b0};
    tbl[3] = '{"timeout",  4'b0001, 4'b0000, 64'h0000_0000_0000_DEAD, -1, 0, 0, 2'd0, 1'b1};
    tbl[4] = '{"sticky",   4'b0110, 4'b0010, 64'h0000_1234_5678_0000,  1, 2, 0, 2'd1, 1'b1};
    tbl[5] = '{"stale3",   4'b1000, 4'b1000, 64'hF00D_0000_0000_0000,  3, 1, 1, 2'd3, 1'b1};
    tbl[6] = '{"wrap",     4'b1001, 4'b0000, 64'h9999_0000_0000_8888, 14, 4, 0, 2'd0, 1'b1};

    do_reset(1);
    for (int i = 0; i < 7; i++)
      run_txn(tbl[i].name, tbl[i].req, tbl[i].cd, tbl[i].val, tbl[i].k, tbl[i].blen,
              tbl[i].hold, tbl[i].exp_g, tbl[i].exp_tmo);

    do_reset(0);
    for (int t = 0; t < 20; t++) begin
      logic [3:0]  req, cd;
      logic [63:0] val;
      int          k, blen;
      bit          hold;
      logic [1:0]  g;
      req  = 4'($urandom_range(1, 15));
      cd   = 4'($urandom);
      val  = {$urandom, $urandom};
      k    = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 15));
      blen = int'($urandom_range(1, 4));
      hold = ($countones(req) == 1) && ($urandom_range(0, 1) == 1);
      g    = model_pick(req, m_last);
      run_txn($sformatf("rand%0d", t), req, cd, val, k, blen, hold, g, m_tmo | (k < 0));
    end

    rr_sequence();
    reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_cdroutine_rr_scheduler
`default_nettype wire
